alu_op_sequencer: RTL and testbench

Multi-cycle command sequencer that drives the 8-bit ALU from the producer side: it owns a 4x8 register file, issues op/operand pairs to the ALU, and samples the ALU result and zero flag. Commands arrive on a valid/ready handshake. Results leave on a valid/ready handshake. Sits between the CPU control path and the combinational ALU (3-bit op code, operands a/b, result y, flag zero).

---
 rtl/alu_op_sequencer_if.sv | 28 ++
 rtl/alu_op_sequencer.sv | 133 +++++++++++++
 tb/tb_alu_op_sequencer.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Command/result handshake bundle between the CPU control path and alu_op_sequencer.
// master = producer/consumer side, slave = sequencer side.
interface alu_op_sequencer_if #(
  parameter int W = 8
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_load;
  logic [2:0]   cmd_op;
  logic [1:0]   cmd_rd;
  logic [1:0]   cmd_ra;
  logic [1:0]   cmd_rb;
  logic [W-1:0] cmd_imm;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic         res_zero;

  modport master (
    output cmd_valid, cmd_load, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm, res_ready,
    input  cmd_ready, res_valid, res_data, res_zero
  );

  modport slave (
    input  cmd_valid, cmd_load, cmd_op, cmd_rd, cmd_ra, cmd_rb, cmd_imm, res_ready,
    output cmd_ready, res_valid, res_data, res_zero
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// IDLE/EXEC/DONE sequencer owning a small register file and driving an external combinational ALU.
// Optional macro ALU_ZERO_CHECK_EN enables a sticky ALU zero-flag consistency error (err).
module alu_op_sequencer #(
  parameter int NREGS = 4,
  parameter int W     = 8
) (
  input  logic                clk,
  input  logic                reset,
  alu_op_sequencer_if.slave   bus,
  output logic [W-1:0]        alu_a,
  output logic [W-1:0]        alu_b,
  output logic [2:0]          alu_op,
  input  logic [W-1:0]        alu_y,
  input  logic                alu_zero,
  output logic                z_flag,
  input  logic [1:0]          dbg_sel,
  output logic [W-1:0]        dbg_data,
  output logic                err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_reg;
  logic [1:0]   rd_reg;
  logic [W-1:0] res_data_reg;
  logic         res_zero_reg;
  logic [W-1:0] regs [NREGS];

  logic         wr_en;
  logic [1:0]   wr_addr;
  logic [W-1:0] wr_data;

  assign bus.cmd_ready = (state_reg == IDLE);
  assign bus.res_valid = (state_reg == DONE);
  assign bus.res_data  = res_data_reg;
  assign bus.res_zero  = res_zero_reg;
  assign dbg_data      = regs[dbg_sel];

  // Loads write on the accept edge; ALU results write on the closing edge of EXEC.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = bus.cmd_rd;
    wr_data = bus.cmd_imm;
    if (state_reg == EXEC) begin
      wr_en   = 1'b1;
      wr_addr = rd_reg;
      wr_data = alu_y;
    end else if (state_reg == IDLE && bus.cmd_valid && bus.cmd_load) begin
      wr_en   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      rd_reg       <= '0;
      res_data_reg <= '0;
      res_zero_reg <= 1'b0;
      z_flag       <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.cmd_valid) begin
            rd_reg <= bus.cmd_rd;
            if (bus.cmd_load) begin
              res_data_reg <= bus.cmd_imm;
              res_zero_reg <= (bus.cmd_imm == '0);
              z_flag       <= (bus.cmd_imm == '0);
              state_reg    <= DONE;
            end else begin
              // Operands are latched here, so a write to rd in EXEC cannot disturb them.
              alu_a     <= regs[bus.cmd_ra];
              alu_b     <= regs[bus.cmd_rb];
              alu_op    <= bus.cmd_op;
              state_reg <= EXEC;
            end
          end
        end
        EXEC: begin
          res_data_reg <= alu_y;
          res_zero_reg <= alu_zero;
          z_flag       <= alu_zero;
          alu_a        <= '0;
          alu_b        <= '0;
          alu_op       <= '0;
          state_reg    <= DONE;
        end
        DONE: begin
          if (bus.res_ready) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_ZERO_CHECK_EN
  logic err_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_reg <= 1'b0;
    end else if (state_reg == EXEC && (alu_zero != (alu_y == '0))) begin
      err_reg <= 1'b1;
    end
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: a reference ALU model drives alu_y/alu_zero,
// expected results are queued on command accept and compared on result handshake.
module tb_alu_op_sequencer;

  logic       clk;
  logic       reset;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_y;
  logic       alu_zero;
  logic       z_flag;
  logic [1:0] dbg_sel;
  logic [7:0] dbg_data;
  logic       err;
  logic       zero_flip;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] data;
    logic       zero;
    logic [1:0] rd;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] mregs [4];

  alu_op_sequencer_if #(.W(8)) bus ();

  alu_op_sequencer #(.NREGS(4), .W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_y    (alu_y),
    .alu_zero (alu_zero),
    .z_flag   (z_flag),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return a;
      3'd1:    return ~a;
      3'd2:    return a + b;
      3'd3:    return a - b;
      3'd4:    return a & b;
      3'd5:    return a | b;
      3'd6:    return 8'd0 - a;
      default: return 8'd0 - b;
    endcase
  endfunction

  always_comb begin
    alu_y    = alu_ref(alu_op, alu_a, alu_b);
    alu_zero = (alu_y == 8'd0) ^ zero_flip;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_cmd(input logic ld, input logic [2:0] op, input logic [1:0] rd,
                           input logic [1:0] ra, input logic [1:0] rb, input logic [7:0] imm);
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = ld;
    bus.cmd_op    = op;
    bus.cmd_rd    = rd;
    bus.cmd_ra    = ra;
    bus.cmd_rb    = rb;
    bus.cmd_imm   = imm;
  endtask

  // Model update at accept: operands read before rd is overwritten.
  task automatic push_expect(input logic ld, input logic [2:0] op, input logic [1:0] rd,
                             input logic [1:0] ra, input logic [1:0] rb, input logic [7:0] imm);
    exp_t e;
    e.data = ld ? imm : alu_ref(op, mregs[ra], mregs[rb]);
    e.zero = ld ? (imm == 8'd0) : ((e.data == 8'd0) ^ zero_flip);
    e.rd   = rd;
    mregs[rd] = e.data;
    sb.push_back(e);
  endtask

  task automatic send(input logic ld, input logic [2:0] op, input logic [1:0] rd,
                      input logic [1:0] ra, input logic [1:0] rb, input logic [7:0] imm);
    int n;
    logic [7:0] ea;
    logic [7:0] eb;
    @(negedge clk);
    drive_cmd(ld, op, rd, ra, rb, imm);
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      bus.cmd_valid = 1'b0;
      return;
    end
    ea = mregs[ra];
    eb = mregs[rb];
    push_expect(ld, op, rd, ra, rb, imm);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    if (ld) begin
      chk("load_latency", 32'(bus.res_valid), 32'd1);
    end else begin
      chk("exec_op", 32'(alu_op), 32'(op));
      chk("exec_a", 32'(alu_a), 32'(ea));
      chk("exec_b", 32'(alu_b), 32'(eb));
      chk("exec_res_valid", 32'(bus.res_valid), 32'd0);
      chk("exec_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      @(negedge clk);
      chk("alu_latency", 32'(bus.res_valid), 32'd1);
      chk("alu_op_idle", 32'(alu_op), 32'd0);
    end
  endtask

  task automatic collect(input int hold);
    int n;
    exp_t e;
    logic [7:0] d0;
    n = 0;
    while (!bus.res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.res_valid) begin
      chk("result_timeout", 32'd0, 32'd1);
      return;
    end
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
      return;
    end
    e  = sb.pop_front();
    d0 = bus.res_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.res_valid), 32'd1);
      chk("hold_data", 32'(bus.res_data), 32'(d0));
      chk("hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    end
    chk("res_data", 32'(bus.res_data), 32'(e.data));
    chk("res_zero", 32'(bus.res_zero), 32'(e.zero));
    chk("z_flag", 32'(z_flag), 32'(e.zero));
    dbg_sel = e.rd;
    #1 chk("dbg_rd", 32'(dbg_data), 32'(e.data));
    $display("txn rd=%0d data=%02h zero=%0b hold=%0d", e.rd, bus.res_data, bus.res_zero, hold);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] d0;
    reset         = 1'b0;
    zero_flip     = 1'b0;
    dbg_sel       = 2'd0;
    bus.res_ready = 1'b0;
    drive_cmd(1'b0, 3'd0, 2'd0, 2'd0, 2'd0, 8'd0);
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) mregs[i] = 8'd0;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1 chk("reset_reg", 32'(dbg_data), 32'd0);
    end
    chk("reset_res_valid", 32'(bus.res_valid), 32'd0);
    chk("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("reset_alu_op", 32'(alu_op), 32'd0);
    chk("reset_z_flag", 32'(z_flag), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Loads, then subtraction giving zero.
    send(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h05); collect(0);
    send(1'b1, 3'd0, 2'd2, 2'd0, 2'd0, 8'h05); collect(0);
    dbg_sel = 2'd1;
    #1 chk("dbg_r1", 32'(dbg_data), 32'h05);
    send(1'b0, 3'd3, 2'd3, 2'd1, 2'd2, 8'h00); collect(0);

    // Wrapping add with rd == ra.
    send(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'hFF); collect(0);
    send(1'b1, 3'd0, 2'd2, 2'd0, 2'd0, 8'h02); collect(0);
    send(1'b0, 3'd2, 2'd1, 2'd1, 2'd2, 8'h00); collect(0);

    // Backpressure with a pending command held by the producer.
    send(1'b0, 3'd5, 2'd0, 2'd1, 2'd2, 8'h00);
    @(negedge clk);
    drive_cmd(1'b1, 3'd0, 2'd3, 2'd0, 2'd0, 8'hA5);
    d0 = bus.res_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(bus.res_valid), 32'd1);
      chk("bp_data", 32'(bus.res_data), 32'(d0));
      chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    end
    bus.cmd_valid = 1'b0;
    collect(0);
    @(negedge clk);
    chk("bp_idle_ready", 32'(bus.cmd_ready), 32'd1);
    chk("bp_idle_valid", 32'(bus.res_valid), 32'd0);
    send(1'b1, 3'd0, 2'd3, 2'd0, 2'd0, 8'hA5); collect(0);

    // Randomised mix with variable consumer stalls.
    for (int k = 0; k < 24; k++) begin
      send(1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 255)));
      collect(int'($urandom_range(0, 2)));
    end

`ifdef ALU_ZERO_CHECK_EN
    send(1'b1, 3'd0, 2'd0, 2'd0, 2'd0, 8'h01); collect(0);
    send(1'b1, 3'd0, 2'd1, 2'd0, 2'd0, 8'h02); collect(0);
    zero_flip = 1'b1;
    send(1'b0, 3'd2, 2'd2, 2'd0, 2'd1, 8'h00); collect(0);
    zero_flip = 1'b0;
    chk("err_set", 32'(err), 32'd1);
    send(1'b0, 3'd2, 2'd3, 2'd0, 2'd1, 8'h00); collect(0);
    chk("err_sticky", 32'(err), 32'd1);
`else
    chk("err_tied", 32'(err), 32'd0);
`endif

    // Reset while in EXEC aborts the command.
    @(negedge clk);
    drive_cmd(1'b0, 3'd2, 2'd0, 2'd1, 2'd2, 8'h00);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst_in_exec", 32'(alu_op), 32'd2);
    reset = 1'b0;
    #1;
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1 chk("rst_reg", 32'(dbg_data), 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) mregs[i] = 8'd0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_result", 32'(bus.res_valid), 32'd0);
    end
    chk("rst_z_flag", 32'(z_flag), 32'd0);
    send(1'b0, 3'd1, 2'd0, 2'd3, 2'd3, 8'h00); collect(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
